// File: rtl/reward_pkg.sv
// Shared types and constants for reward_arbiter and its sub-blocks.
package reward_pkg;

    // On-air packet type encodings.
    typedef enum logic [2:0] {
        PKT_HB      = 3'b000,
        PKT_CHE     = 3'b001,
        PKT_INV     = 3'b010,
        PKT_MR      = 3'b011,
        PKT_CHT     = 3'b100,
        PKT_DATA    = 3'b101,
        PKT_SOS     = 3'b110,
        PKT_INVALID = 3'b111
    } pkt_type_e;

    // Request slots; lower index wins arbitration.
    typedef enum logic [2:0] {
        REQ_HB    = 3'd0,
        REQ_INV   = 3'd1,
        REQ_MR    = 3'd2,
        REQ_FWD   = 3'd3,
        REQ_CHINV = 3'd4,
        REQ_CHT   = 3'd5,
        REQ_SRC   = 3'd6
    } req_idx_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SELECT,
        ST_HOLD,
        ST_DONE
    } state_e;

    localparam int unsigned NUM_REQ = 7;

    // Wide enough for any WORD_WIDTH; users truncate to their field width.
    localparam logic [63:0] BROADCAST_ID = '1;

    // Highest-priority pending request; only meaningful when pend is non-zero.
    function automatic req_idx_e pick_winner(input logic [NUM_REQ-1:0] pend);
        req_idx_e w;
        logic     found;
        w     = REQ_SRC;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!found && pend[i]) begin
                w     = req_idx_e'(3'(i));
                found = 1'b1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/reward_arbiter_if.sv
// Valid/ready packet bus from reward_arbiter toward the radio/CSMA block.
interface reward_arbiter_if #(
    parameter int unsigned WORD_WIDTH = 16
) ();
    logic                  rValid;
    logic                  rReady;
    logic [2:0]            rPacketType;
    logic [WORD_WIDTH-1:0] rSourceID;
    logic [WORD_WIDTH-1:0] rEnergyLeft;
    logic [WORD_WIDTH-1:0] rQValue;
    logic [WORD_WIDTH-1:0] rSourceHops;
    logic [WORD_WIDTH-1:0] rDestinationID;
    logic [WORD_WIDTH-1:0] rChosenCH;
    logic [WORD_WIDTH-1:0] rHopsFromCH;

    modport master (
        output rValid, rPacketType, rSourceID, rEnergyLeft, rQValue,
               rSourceHops, rDestinationID, rChosenCH, rHopsFromCH,
        input  rReady
    );

    modport slave (
        input  rValid, rPacketType, rSourceID, rEnergyLeft, rQValue,
               rSourceHops, rDestinationID, rChosenCH, rHopsFromCH,
        output rReady
    );
endinterface

// File: rtl/reward_timer.sv
// Loadable down-counter: arm loads LOAD, counts to zero once, pulses expire_o
// in the cycle whose clock edge brings the count to zero, then stops.
module reward_timer #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned LOAD  = 15
) (
    input  logic clk,
    input  logic nrst,
    input  logic arm_i,
    output logic expire_o
);

    logic [WIDTH-1:0] count_q, count_d;
    logic             running_q, running_d;

    // Next count; a re-arm reloads and suppresses any expiry in that cycle.
    always_comb begin
        count_d   = count_q;
        running_d = running_q;
        expire_o  = 1'b0;
        if (arm_i) begin
            count_d   = WIDTH'(LOAD);
            running_d = 1'b1;
        end else if (running_q) begin
            if (count_q <= WIDTH'(1)) begin
                count_d   = '0;
                running_d = 1'b0;
                expire_o  = 1'b1;
            end else begin
                count_d = count_q - WIDTH'(1);
            end
        end
    end

    // Counter state register.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            count_q   <= '0;
            running_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            running_q <= running_d;
        end
    end

endmodule

// File: rtl/reward_arbiter.sv
// Reward packer: latches transmit triggers as pending requests, arbitrates
// them by fixed priority and emits one packet at a time on a valid/ready bus.
// Optional macro REWARD_SOS_EN: send SRC/FWD as SOS when low_E, and keep an
// incoming SOS type when forwarding.
module reward_arbiter
    import reward_pkg::*;
#(
    parameter int unsigned WORD_WIDTH  = 16,
    parameter int unsigned MAX_CH_HOPS = 4,
    parameter int unsigned MR_TIMEOUT  = 15,
    parameter int unsigned CHT_TIMEOUT = 15,
    parameter int unsigned TIMER_WIDTH = 16,
    parameter int unsigned SINK_ID     = 0
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  en,
    input  logic [2:0]            fPacketType,
    input  logic                  iAmDestination,
    input  logic [WORD_WIDTH-1:0] mNodeID,
    input  logic [WORD_WIDTH-1:0] mNodeHops,
    input  logic [WORD_WIDTH-1:0] mNodeQValue,
    input  logic [WORD_WIDTH-1:0] mNodeEnergy,
    input  logic [WORD_WIDTH-1:0] mChosenCH,
    input  logic [WORD_WIDTH-1:0] mNodeCHHops,
    input  logic [WORD_WIDTH-1:0] myNodeID,
    input  logic [WORD_WIDTH-1:0] hopsFromSink,
    input  logic [WORD_WIDTH-1:0] myQValue,
    input  logic [WORD_WIDTH-1:0] myEnergy,
    input  logic [WORD_WIDTH-1:0] chosenCH,
    input  logic [WORD_WIDTH-1:0] chosenHop,
    input  logic                  role,
    input  logic                  low_E,
    input  logic                  cf_start,
    input  logic                  iAmSender,
    reward_arbiter_if.master      r_if,
    output logic                  reward_done,
    output logic                  busy,
    output logic [7:0]            drop_cnt
);

    localparam logic [WORD_WIDTH-1:0] BCAST = WORD_WIDTH'(BROADCAST_ID);
    localparam logic [WORD_WIDTH-1:0] MAXH  = WORD_WIDTH'(MAX_CH_HOPS);

    state_e               state_q, state_d;
    req_idx_e             cur_q, cur_d, win;
    logic [NUM_REQ-1:0]   pend_q, pend_d, pend_set, pend_clr;
    logic                 hblock_q, hblock_d;
    logic                 role_q;
    logic [7:0]           drop_q, drop_d;

    pkt_type_e             type_q, type_d;
    logic [WORD_WIDTH-1:0] src_q, src_d, nrg_q, nrg_d, qv_q, qv_d, hops_q, hops_d;
    logic [WORD_WIDTH-1:0] dst_q, dst_d, ch_q, ch_d, hch_q, hch_d;

    logic                  slot_vld_q, slot_vld_d;
    logic [WORD_WIDTH-1:0] slot_id_q, slot_nrg_q, slot_qv_q, slot_hops_q, slot_ch_q, slot_chh_q;

    logic inv_cand, fwd_cand, ev_hb, ev_inv, ev_fwd, ev_chinv, ev_src, cap_drop, capture;
    logic mr_expire, cht_expire, mr_arm, cht_arm, handshake;
    logic [WORD_WIDTH-1:0] route_dst;
    pkt_type_e src_type, fwd_type;

    assign inv_cand  = en && (fPacketType == PKT_INV) && (mNodeCHHops < MAXH);
    assign fwd_cand  = en && ((fPacketType == PKT_DATA) || (fPacketType == PKT_SOS)) && iAmDestination;
    assign ev_inv    = inv_cand && !slot_vld_q;
    assign ev_fwd    = fwd_cand && !slot_vld_q;
    assign capture   = ev_inv || ev_fwd;
    assign cap_drop  = (inv_cand || fwd_cand) && slot_vld_q;
    assign ev_hb     = en && (fPacketType == PKT_HB) && !hblock_q;
    assign ev_chinv  = role && !role_q;
    assign ev_src    = iAmSender;
    assign handshake = (state_q == ST_HOLD) && r_if.rReady;
    assign mr_arm    = cf_start && !role;
    assign cht_arm   = handshake && (cur_q == REQ_CHINV);
    assign route_dst = (hopsFromSink == WORD_WIDTH'(1)) ? WORD_WIDTH'(SINK_ID) : chosenHop;

`ifdef REWARD_SOS_EN
    logic slot_sos_q;

    assign src_type = low_E ? PKT_SOS : PKT_DATA;
    assign fwd_type = (low_E || slot_sos_q) ? PKT_SOS : PKT_DATA;

    // Remember whether the captured forward arrived as SOS.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            slot_sos_q <= 1'b0;
        end else if (capture) begin
            slot_sos_q <= (fPacketType == PKT_SOS);
        end
    end
`else
    logic unused_low_e;

    assign unused_low_e = low_E;
    assign src_type     = PKT_DATA;
    assign fwd_type     = PKT_DATA;
`endif

    reward_timer #(.WIDTH(TIMER_WIDTH), .LOAD(MR_TIMEOUT)) u_mr_timer (
        .clk      (clk),
        .nrst     (nrst),
        .arm_i    (mr_arm),
        .expire_o (mr_expire)
    );

    reward_timer #(.WIDTH(TIMER_WIDTH), .LOAD(CHT_TIMEOUT)) u_cht_timer (
        .clk      (clk),
        .nrst     (nrst),
        .arm_i    (cht_arm),
        .expire_o (cht_expire)
    );

    // Pending-flag set/clear, HB lock, slot occupancy and drop counter.
    always_comb begin
        pend_set            = '0;
        pend_set[REQ_HB]    = ev_hb;
        pend_set[REQ_INV]   = ev_inv;
        pend_set[REQ_MR]    = mr_expire;
        pend_set[REQ_FWD]   = ev_fwd;
        pend_set[REQ_CHINV] = ev_chinv;
        pend_set[REQ_CHT]   = cht_expire;
        pend_set[REQ_SRC]   = ev_src;
        // A new event in the same cycle as its own clear stays pending.
        pend_d = (pend_q & ~pend_clr) | pend_set;

        hblock_d = hblock_q;
        if (ev_hb) begin
            hblock_d = 1'b1;
        end else if (en && (fPacketType == PKT_DATA)) begin
            hblock_d = 1'b0;
        end

        slot_vld_d = slot_vld_q;
        if (capture) begin
            slot_vld_d = 1'b1;
        end else if (handshake && ((cur_q == REQ_INV) || (cur_q == REQ_FWD))) begin
            slot_vld_d = 1'b0;
        end

        drop_d = drop_q;
        if (cap_drop && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
    end

    // FSM next state plus field selection for the arbitration winner.
    always_comb begin
        state_d  = state_q;
        cur_d    = cur_q;
        pend_clr = '0;
        win      = pick_winner(pend_q);
        type_d   = type_q;
        src_d    = src_q;
        nrg_d    = nrg_q;
        qv_d     = qv_q;
        hops_d   = hops_q;
        dst_d    = dst_q;
        ch_d     = ch_q;
        hch_d    = hch_q;
        unique case (state_q)
            ST_IDLE: begin
                if (|pend_q) state_d = ST_SELECT;
            end
            ST_SELECT: begin
                pend_clr[win] = 1'b1;
                cur_d         = win;
                src_d         = myNodeID;
                nrg_d         = myEnergy;
                qv_d          = myQValue;
                hops_d        = hopsFromSink;
                ch_d          = chosenCH;
                hch_d         = '0;
                dst_d         = BCAST;
                case (win)
                    REQ_HB:    type_d = PKT_HB;
                    REQ_MR: begin
                        type_d = PKT_MR;
                        dst_d  = chosenCH;
                    end
                    REQ_CHINV: begin
                        type_d = PKT_INV;
                        ch_d   = myNodeID;
                        hch_d  = WORD_WIDTH'(1);
                    end
                    REQ_CHT:   type_d = PKT_CHT;
                    REQ_SRC: begin
                        type_d = src_type;
                        dst_d  = route_dst;
                    end
                    REQ_INV, REQ_FWD: begin
                        src_d  = slot_id_q;
                        nrg_d  = slot_nrg_q;
                        qv_d   = slot_qv_q;
                        hops_d = slot_hops_q;
                        ch_d   = slot_ch_q;
                        if (win == REQ_INV) begin
                            type_d = PKT_INV;
                            hch_d  = slot_chh_q + WORD_WIDTH'(1);
                        end else begin
                            type_d = fwd_type;
                            dst_d  = route_dst;
                            hch_d  = slot_chh_q;
                        end
                    end
                    default: ;
                endcase
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (r_if.rReady) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Control, request and output-field registers.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q  <= ST_IDLE;
            cur_q    <= REQ_HB;
            pend_q   <= '0;
            hblock_q <= 1'b0;
            role_q   <= 1'b0;
            drop_q   <= '0;
            slot_vld_q <= 1'b0;
            type_q   <= PKT_INVALID;
            src_q    <= '0;
            nrg_q    <= '0;
            qv_q     <= '0;
            hops_q   <= '0;
            dst_q    <= '1;
            ch_q     <= '0;
            hch_q    <= '0;
        end else begin
            state_q  <= state_d;
            cur_q    <= cur_d;
            pend_q   <= pend_d;
            hblock_q <= hblock_d;
            role_q   <= role;
            drop_q   <= drop_d;
            slot_vld_q <= slot_vld_d;
            type_q   <= type_d;
            src_q    <= src_d;
            nrg_q    <= nrg_d;
            qv_q     <= qv_d;
            hops_q   <= hops_d;
            dst_q    <= dst_d;
            ch_q     <= ch_d;
            hch_q    <= hch_d;
        end
    end

    // Capture slot contents for INV ripple and forwarded data.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            slot_id_q   <= '0;
            slot_nrg_q  <= '0;
            slot_qv_q   <= '0;
            slot_hops_q <= '0;
            slot_ch_q   <= '0;
            slot_chh_q  <= '0;
        end else if (capture) begin
            slot_id_q   <= mNodeID;
            slot_nrg_q  <= mNodeEnergy;
            slot_qv_q   <= mNodeQValue;
            slot_hops_q <= mNodeHops;
            slot_ch_q   <= mChosenCH;
            slot_chh_q  <= mNodeCHHops;
        end
    end

    assign r_if.rValid         = (state_q == ST_HOLD);
    assign r_if.rPacketType    = type_q;
    assign r_if.rSourceID      = src_q;
    assign r_if.rEnergyLeft    = nrg_q;
    assign r_if.rQValue        = qv_q;
    assign r_if.rSourceHops    = hops_q;
    assign r_if.rDestinationID = dst_q;
    assign r_if.rChosenCH      = ch_q;
    assign r_if.rHopsFromCH    = hch_q;
    assign reward_done         = (state_q == ST_DONE);
    assign busy                = (state_q != ST_IDLE);
    assign drop_cnt            = drop_q;

endmodule

// File: tb/tb_reward_arbiter.sv
// Scoreboard bench for reward_arbiter: expected packets are queued when
// stimulus is driven and compared when the DUT raises rValid.
module tb_reward_arbiter;

    typedef struct packed {
        logic [2:0]  ptype;
        logic [15:0] src, energy, q, hops, dst, ch, hch;
    } pkt_s;

    typedef struct {
        pkt_s p;
        bit   care_ch;
        bit   care_hch;
    } exp_t;

    logic clk = 1'b0;
    logic nrst, en, iAmDestination, role, low_E, cf_start, iAmSender;
    logic [2:0]  fPacketType;
    logic [15:0] mNodeID, mNodeHops, mNodeQValue, mNodeEnergy, mChosenCH, mNodeCHHops;
    logic [15:0] myNodeID, hopsFromSink, myQValue, myEnergy, chosenCH, chosenHop;
    logic        reward_done, busy;
    logic [7:0]  drop_cnt;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   done_seen = 0;
    exp_t exp_q[$];

    reward_arbiter_if #(.WORD_WIDTH(16)) rif ();

    reward_arbiter #(
        .WORD_WIDTH(16), .MAX_CH_HOPS(4), .MR_TIMEOUT(15),
        .CHT_TIMEOUT(15), .TIMER_WIDTH(16), .SINK_ID(0)
    ) dut (
        .clk(clk), .nrst(nrst), .en(en), .fPacketType(fPacketType),
        .iAmDestination(iAmDestination), .mNodeID(mNodeID), .mNodeHops(mNodeHops),
        .mNodeQValue(mNodeQValue), .mNodeEnergy(mNodeEnergy), .mChosenCH(mChosenCH),
        .mNodeCHHops(mNodeCHHops), .myNodeID(myNodeID), .hopsFromSink(hopsFromSink),
        .myQValue(myQValue), .myEnergy(myEnergy), .chosenCH(chosenCH),
        .chosenHop(chosenHop), .role(role), .low_E(low_E), .cf_start(cf_start),
        .iAmSender(iAmSender), .r_if(rif), .reward_done(reward_done), .busy(busy),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    function automatic pkt_s msk(input pkt_s p, input bit care_ch, input bit care_hch);
        pkt_s r = p;
        if (!care_ch)  r.ch  = '0;
        if (!care_hch) r.hch = '0;
        return r;
    endfunction

    function automatic string ps(input pkt_s p);
        return $sformatf("t=%b src=%h e=%h q=%h hops=%h dst=%h ch=%h hch=%h",
                         p.ptype, p.src, p.energy, p.q, p.hops, p.dst, p.ch, p.hch);
    endfunction

    function automatic pkt_s own(input logic [2:0] t, input logic [15:0] dst,
                                 input logic [15:0] ch, input logic [15:0] hch);
        return '{ptype: t, src: myNodeID, energy: myEnergy, q: myQValue,
                 hops: hopsFromSink, dst: dst, ch: ch, hch: hch};
    endfunction

    function automatic pkt_s cur_out();
        return '{ptype: rif.rPacketType, src: rif.rSourceID, energy: rif.rEnergyLeft,
                 q: rif.rQValue, hops: rif.rSourceHops, dst: rif.rDestinationID,
                 ch: rif.rChosenCH, hch: rif.rHopsFromCH};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        if (reward_done === 1'b1) done_seen++;
    endtask

    task automatic push(input pkt_s p, input bit care_ch, input bit care_hch);
        exp_t e;
        e.p = p; e.care_ch = care_ch; e.care_hch = care_hch;
        exp_q.push_back(e);
    endtask

    // Wait (bounded) for rValid; returns the observed packet and expectation.
    task automatic collect(input int max_cyc, output pkt_s obs, output exp_t e, output bit got);
        got = 1'b0;
        obs = '0;
        for (int i = 0; i <= max_cyc && !got; i++) begin
            if (rif.rValid === 1'b1) begin
                got = 1'b1;
                obs = cur_out();
            end else begin
                step();
            end
        end
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else e = '{p: '1, care_ch: 1'b1, care_hch: 1'b1};
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && busy !== 1'b0; i++) step();
        step();
    endtask

    task automatic strobe_en(input logic [2:0] t, input logic dest);
        fPacketType = t; iAmDestination = dest; en = 1'b1;
        step();
        en = 1'b0; iAmDestination = 1'b0;
    endtask

    task automatic test_reset();
        pkt_s obs;
        pkt_s exp_p;
        nrst = 1'b0;
        step(); step();
        exp_p = '{ptype: 3'b111, src: 0, energy: 0, q: 0, hops: 0, dst: 16'hFFFF, ch: 0, hch: 0};
        n_checks++;
        if ({rif.rValid, reward_done, busy, drop_cnt} !== 11'b0)
            $display("FAIL reset_status: got v=%b done=%b busy=%b drop=%0d required all 0",
                     rif.rValid, reward_done, busy, drop_cnt);
        else n_pass++;
        obs = cur_out();
        n_checks++;
        if (obs !== exp_p) $display("FAIL reset_fields: got %s required %s", ps(obs), ps(exp_p));
        else n_pass++;
        nrst = 1'b1;
        step();
    endtask

    task automatic test_hb();
        pkt_s obs; exp_t e; bit got; bit early; bit saw_busy;
        mNodeID = 16'h1111; mNodeEnergy = 16'h2222; mNodeQValue = 16'h3333;
        push(own(3'b000, 16'hFFFF, 16'h0, 16'h0), 1'b0, 1'b1);
        strobe_en(3'b000, 1'b0);
        early = rif.rValid;
        step();
        early = early | rif.rValid;
        n_checks++;
        if (early !== 1'b0) $display("FAIL hb_early: rValid=1 before cycle +2, required 0");
        else n_pass++;
        step();
        n_checks++;
        if (rif.rValid !== 1'b1) $display("FAIL hb_latency: rValid=%b at cycle +2, required 1", rif.rValid);
        else n_pass++;
        collect(10, obs, e, got);
        n_checks++;
        if (!got || msk(obs, e.care_ch, e.care_hch) !== msk(e.p, e.care_ch, e.care_hch))
            $display("FAIL hb_pkt: got(%0d) %s required %s", got, ps(obs), ps(e.p));
        else n_pass++;
        wait_idle();
        strobe_en(3'b000, 1'b0);
        saw_busy = 1'b0;
        for (int i = 0; i < 6; i++) begin saw_busy |= busy; step(); end
        n_checks++;
        if (saw_busy !== 1'b0) $display("FAIL hb_lock: busy=1 after locked HB, required 0");
        else n_pass++;
        strobe_en(3'b101, 1'b0);
        wait_idle();
        push(own(3'b000, 16'hFFFF, 16'h0, 16'h0), 1'b0, 1'b1);
        strobe_en(3'b000, 1'b0);
        collect(10, obs, e, got);
        n_checks++;
        if (!got || msk(obs, e.care_ch, e.care_hch) !== msk(e.p, e.care_ch, e.care_hch))
            $display("FAIL hb_unlock_pkt: got(%0d) %s required %s", got, ps(obs), ps(e.p));
        else n_pass++;
        wait_idle();
    endtask

    task automatic test_inv();
        pkt_s obs; exp_t e; bit got; bit saw_busy;
        mNodeID = 16'h0101; mNodeEnergy = 16'h0202; mNodeQValue = 16'h0303;
        mNodeHops = 16'h0004; mChosenCH = 16'h0505; mNodeCHHops = 16'd3;
        push('{ptype: 3'b010, src: 16'h0101, energy: 16'h0202, q: 16'h0303, hops: 16'h0004,
               dst: 16'hFFFF, ch: 16'h0505, hch: 16'd4}, 1'b1, 1'b1);
        strobe_en(3'b010, 1'b0);
        collect(10, obs, e, got);
        n_checks++;
        if (!got || msk(obs, e.care_ch, e.care_hch) !== msk(e.p, e.care_ch, e.care_hch))
            $display("FAIL inv_ripple: got(%0d) %s required %s", got, ps(obs), ps(e.p));
        else n_pass++;
        wait_idle();
        mNodeCHHops = 16'd4;
        strobe_en(3'b010, 1'b0);
        saw_busy = 1'b0;
        for (int i = 0; i < 6; i++) begin saw_busy |= busy; step(); end
        n_checks++;
        if (saw_busy !== 1'b0) $display("FAIL inv_max_hops: busy=1, required 0");
        else n_pass++;
    endtask

    task automatic test_mr();
        pkt_s obs; exp_t e; bit got; int n;
        push(own(3'b011, chosenCH, 16'h0, 16'h0), 1'b0, 1'b0);
        cf_start = 1'b1;
        step();
        cf_start = 1'b0;
        n = 0;
        while (rif.rValid !== 1'b1 && n < 40) begin step(); n++; end
        n_checks++;
        if (n != 17) $display("FAIL mr_latency: rValid after %0d cycles, required 17", n);
        else n_pass++;
        collect(2, obs, e, got);
        n_checks++;
        if (!got || msk(obs, e.care_ch, e.care_hch) !== msk(e.p, e.care_ch, e.care_hch))
            $display("FAIL mr_pkt: got(%0d) %s required %s", got, ps(obs), ps(e.p));
        else n_pass++;
        wait_idle();
    endtask

    task automatic test_fwd_hold();
        pkt_s obs; exp_t e; bit got; bit stable;
        rif.rReady = 1'b0;
        mNodeID = 16'h0A0A; mNodeEnergy = 16'h0B0B; mNodeQValue = 16'h0C0C;
        mNodeHops = 16'h0006; mChosenCH = 16'h0D0D; mNodeCHHops = 16'd2;
        push('{ptype: 3'b101, src: 16'h0A0A, energy: 16'h0B0B, q: 16'h0C0C, hops: 16'h0006,
               dst: chosenHop, ch: 16'h0D0D, hch: 16'd2}, 1'b1, 1'b1);
        strobe_en(3'b101, 1'b1);
        collect(10, obs, e, got);
        n_checks++;
        if (!got || msk(obs, e.care_ch, e.care_hch) !== msk(e.p, e.care_ch, e.care_hch))
            $display("FAIL fwd_pkt: got(%0d) %s required %s", got, ps(obs), ps(e.p));
        else n_pass++;
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                mNodeID = 16'h7777;
                strobe_en(3'b101, 1'b1);
            end else begin
                step();
            end
            if (rif.rValid !== 1'b1 || cur_out() !== obs) stable = 1'b0;
        end
        n_checks++;
        if (!stable) $display("FAIL fwd_stable: fields/rValid changed during hold, now %s required %s",
                              ps(cur_out()), ps(obs));
        else n_pass++;
        n_checks++;
        if (drop_cnt !== 8'd1) $display("FAIL fwd_drop: drop_cnt=%0d required 1", drop_cnt);
        else n_pass++;
        rif.rReady = 1'b1;
        wait_idle();
    endtask

    task automatic test_back_to_back();
        pkt_s obs; exp_t e; bit got; int base;
        hopsFromSink = 16'd1;
        strobe_en(3'b101, 1'b0);
        wait_idle();
        base = done_seen;
        push(own(3'b000, 16'hFFFF, 16'h0, 16'h0), 1'b0, 1'b1);
        push(own(3'b101, 16'h0000, 16'h0, 16'h0), 1'b0, 1'b1);
        fPacketType = 3'b000; en = 1'b1; iAmSender = 1'b1;
        step();
        en = 1'b0; iAmSender = 1'b0;
        collect(10, obs, e, got);
        n_checks++;
        if (!got || msk(obs, e.care_ch, e.care_hch) !== msk(e.p, e.care_ch, e.care_hch))
            $display("FAIL b2b_first: got(%0d) %s required %s", got, ps(obs), ps(e.p));
        else n_pass++;
        step();
        collect(10, obs, e, got);
        n_checks++;
        if (!got || msk(obs, e.care_ch, e.care_hch) !== msk(e.p, e.care_ch, e.care_hch))
            $display("FAIL b2b_second: got(%0d) %s required %s", got, ps(obs), ps(e.p));
        else n_pass++;
        step(); step(); step();
        n_checks++;
        if (done_seen - base != 2) $display("FAIL b2b_done: reward_done pulses=%0d required 2", done_seen - base);
        else n_pass++;
        hopsFromSink = 16'd3;
        wait_idle();
    endtask

    task automatic test_sos();
        pkt_s obs; exp_t e; bit got;
        logic [2:0] t_src, t_fwd;
`ifdef REWARD_SOS_EN
        t_src = 3'b110; t_fwd = 3'b110;
`else
        t_src = 3'b101; t_fwd = 3'b101;
`endif
        low_E = 1'b1;
        push(own(t_src, chosenHop, 16'h0, 16'h0), 1'b0, 1'b1);
        iAmSender = 1'b1;
        step();
        iAmSender = 1'b0;
        collect(10, obs, e, got);
        n_checks++;
        if (!got || msk(obs, e.care_ch, e.care_hch) !== msk(e.p, e.care_ch, e.care_hch))
            $display("FAIL sos_src: got(%0d) %s required %s", got, ps(obs), ps(e.p));
        else n_pass++;
        low_E = 1'b0;
        wait_idle();
        mNodeID = 16'h0E0E; mNodeCHHops = 16'd1;
        push('{ptype: t_fwd, src: 16'h0E0E, energy: mNodeEnergy, q: mNodeQValue, hops: mNodeHops,
               dst: chosenHop, ch: mChosenCH, hch: 16'd1}, 1'b1, 1'b1);
        strobe_en(3'b110, 1'b1);
        collect(10, obs, e, got);
        n_checks++;
        if (!got || msk(obs, e.care_ch, e.care_hch) !== msk(e.p, e.care_ch, e.care_hch))
            $display("FAIL sos_fwd: got(%0d) %s required %s", got, ps(obs), ps(e.p));
        else n_pass++;
        wait_idle();
    endtask

    task automatic test_chinv_cht();
        pkt_s obs; exp_t e; bit got;
        push(own(3'b010, 16'hFFFF, myNodeID, 16'd1), 1'b1, 1'b1);
        push(own(3'b100, 16'hFFFF, 16'h0, 16'h0), 1'b0, 1'b0);
        role = 1'b1;
        step();
        collect(10, obs, e, got);
        n_checks++;
        if (!got || msk(obs, e.care_ch, e.care_hch) !== msk(e.p, e.care_ch, e.care_hch))
            $display("FAIL chinv_pkt: got(%0d) %s required %s", got, ps(obs), ps(e.p));
        else n_pass++;
        step();
        collect(30, obs, e, got);
        n_checks++;
        if (!got || msk(obs, e.care_ch, e.care_hch) !== msk(e.p, e.care_ch, e.care_hch))
            $display("FAIL cht_pkt: got(%0d) %s required %s", got, ps(obs), ps(e.p));
        else n_pass++;
        role = 1'b0;
        wait_idle();
    endtask

    task automatic test_reset_mid();
        bit saw_busy; bit got;
        strobe_en(3'b101, 1'b0);
        rif.rReady = 1'b0;
        strobe_en(3'b000, 1'b0);
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            if (rif.rValid === 1'b1) got = 1'b1; else step();
        end
        nrst = 1'b0;
        step();
        n_checks++;
        if (!got || rif.rValid !== 1'b0 || busy !== 1'b0)
            $display("FAIL reset_mid: reached_hold=%0d rValid=%b busy=%b required hold then 0/0",
                     got, rif.rValid, busy);
        else n_pass++;
        nrst = 1'b1;
        rif.rReady = 1'b1;
        saw_busy = 1'b0;
        for (int i = 0; i < 6; i++) begin step(); saw_busy |= busy; end
        n_checks++;
        if (saw_busy !== 1'b0) $display("FAIL reset_abandon: busy=1 after reset, required 0");
        else n_pass++;
    endtask

    initial begin
        nrst = 1'b0; en = 1'b0; fPacketType = 3'b111; iAmDestination = 1'b0;
        role = 1'b0; low_E = 1'b0; cf_start = 1'b0; iAmSender = 1'b0;
        mNodeID = '0; mNodeHops = '0; mNodeQValue = '0; mNodeEnergy = '0;
        mChosenCH = '0; mNodeCHHops = '0;
        myNodeID = 16'h0A11; hopsFromSink = 16'd3; myQValue = 16'h0C0C;
        myEnergy = 16'h0E0E; chosenCH = 16'h0CC0; chosenHop = 16'h0BB0;
        rif.rReady = 1'b1;
        test_reset();
        test_hb();
        test_inv();
        test_mr();
        test_fwd_hold();
        test_back_to_back();
        test_sos();
        test_chinv_cht();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
